// File: rtl/jtvigil_romarb_pkg.sv
// Shared definitions for the four-client SDRAM ROM arbiter.
package jtvigil_romarb_pkg;

    localparam int unsigned NumClients = 4;
    localparam int unsigned ClientW    = 2;
    localparam int unsigned NumBeats   = 2;
    localparam int unsigned AddrW      = 17;
    localparam int unsigned BaW        = 22;

    typedef logic [ClientW-1:0] client_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StData
    } state_e;

    // Byte clients address 16-bit words; 32-bit clients span two words each.
    function automatic logic [BaW-1:0] map_addr(input logic [BaW-1:0]   offset,
                                                input logic [AddrW-1:0] addr,
                                                input logic             wide);
        logic [BaW-1:0] word;
        word = wide ? {4'd0, addr, 1'b0} : {6'd0, addr[AddrW-1:1]};
        return offset + word;
    endfunction

endpackage

// File: rtl/jtvigil_romarb_if.sv
// SDRAM bank request/response bus shared by the arbiter and the memory controller.
interface jtvigil_romarb_if;
    import jtvigil_romarb_pkg::*;

    logic [BaW-1:0] ba_addr;
    logic           ba_rd;
    logic           ba_ack;
    logic           ba_dok;
    logic           ba_rdy;
    logic [15:0]    data_read;

    modport master (
        output ba_addr,
        output ba_rd,
        input  ba_ack,
        input  ba_dok,
        input  ba_rdy,
        input  data_read
    );

    modport slave (
        input  ba_addr,
        input  ba_rd,
        output ba_ack,
        output ba_dok,
        output ba_rdy,
        output data_read
    );
endinterface

// File: rtl/jtvigil_romarb_slot.sv
// One-entry client cache: tag/data/valid, hit compare and registered ok.
module jtvigil_romarb_slot
    import jtvigil_romarb_pkg::*;
#(
    parameter int unsigned DataW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic [AddrW-1:0] addr,
    input  logic             fill,
    input  logic [AddrW-1:0] fill_tag,
    input  logic [DataW-1:0] fill_data,
    output logic             hit,
    output logic             ok,
    output logic [DataW-1:0] data
);

    logic             valid_q, valid_d;
    logic [AddrW-1:0] tag_q, tag_d;
    logic [DataW-1:0] data_q, data_d;
    logic             ok_q, ok_d;

    // Hit against the cache as it stands this cycle; drives the miss request.
    assign hit  = cs & valid_q & (addr == tag_q);
    assign ok   = ok_q;
    assign data = data_q;

    // Post-fill cache contents; ok is evaluated against them so a same-cycle fill counts.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            data_d  = fill_data;
        end
        ok_d = cs & valid_d & (addr == tag_d);
    end

    // Cache entry and ok register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            ok_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            ok_q    <= ok_d;
        end
    end

endmodule

// File: rtl/jtvigil_romarb.sv
// Round-robin SDRAM arbiter for two byte-wide CPU clients and two 32-bit graphics clients.
module jtvigil_romarb
    import jtvigil_romarb_pkg::*;
#(
    parameter logic [BaW-1:0] C0_OFFSET = '0,
    parameter logic [BaW-1:0] C1_OFFSET = '0,
    parameter logic [BaW-1:0] C2_OFFSET = '0,
    parameter logic [BaW-1:0] C3_OFFSET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_cs,
    input  logic [AddrW-1:0]  c0_addr,
    output logic [7:0]        c0_data,
    output logic              c0_ok,
    input  logic              c1_cs,
    input  logic [AddrW-1:0]  c1_addr,
    output logic [7:0]        c1_data,
    output logic              c1_ok,
    input  logic              c2_cs,
    input  logic [AddrW-1:0]  c2_addr,
    output logic [31:0]       c2_data,
    output logic              c2_ok,
    input  logic              c3_cs,
    input  logic [AddrW-1:0]  c3_addr,
    output logic [31:0]       c3_data,
    output logic              c3_ok,
    jtvigil_romarb_if.master  sdram
);

    state_e           state_q, state_d;
    client_t          id_q, id_d;
    client_t          ptr_q, ptr_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [BaW-1:0]   ba_addr_q, ba_addr_d;
    logic             beat_q, beat_d;     // a first beat is already held in lo_q
    logic [15:0]      lo_q, lo_d;

    logic [NumClients-1:0] cs, hit, pending, fill_en;
    logic [AddrW-1:0]      cl_addr [NumClients];
    logic [BaW-1:0]        offset  [NumClients];
    logic                  gnt_found;
    client_t               gnt_id;
    logic [15:0]           first_word;
    logic [7:0]            byte_fill;
    logic [31:0]           wide_fill2, wide_fill3;

    assign cs         = {c3_cs, c2_cs, c1_cs, c0_cs};
    assign cl_addr[0] = c0_addr;
    assign cl_addr[1] = c1_addr;
    assign cl_addr[2] = c2_addr;
    assign cl_addr[3] = c3_addr;
    assign offset[0]  = C0_OFFSET;
    assign offset[1]  = C1_OFFSET;
    assign offset[2]  = C2_OFFSET;
    assign offset[3]  = C3_OFFSET;
    assign pending    = cs & ~hit;

    assign sdram.ba_rd   = (state_q == StReq);
    assign sdram.ba_addr = ba_addr_q;

    // Fill data assembly; a 32-bit fill cut short keeps the cached upper half.
    always_comb begin
        first_word = beat_q ? lo_q : sdram.data_read;
        byte_fill  = addr_q[0] ? first_word[15:8] : first_word[7:0];
        wide_fill2 = beat_q ? {sdram.data_read, lo_q} : {c2_data[31:16], sdram.data_read};
        wide_fill3 = beat_q ? {sdram.data_read, lo_q} : {c3_data[31:16], sdram.data_read};
    end

    // Round-robin grant search and transfer FSM next state.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        ba_addr_d = ba_addr_q;
        beat_d    = beat_q;
        lo_d      = lo_q;
        fill_en   = '0;
        gnt_found = 1'b0;
        gnt_id    = ptr_q;
        for (int i = 1; i <= int'(NumClients); i++) begin
            client_t cand;
            cand = ptr_q + client_t'(i);
            if (!gnt_found && pending[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    state_d   = StReq;
                    id_d      = gnt_id;
                    ptr_d     = gnt_id;
                    addr_d    = cl_addr[gnt_id];
                    ba_addr_d = map_addr(offset[gnt_id], cl_addr[gnt_id], gnt_id[1]);
                    beat_d    = 1'b0;
                end
            end
            StReq: begin
                if (sdram.ba_ack) state_d = StData;
            end
            StData: begin
                if (sdram.ba_rdy) begin
                    fill_en[id_q] = 1'b1;
                    state_d       = StIdle;
                end else if (sdram.ba_dok && int'(beat_q) < int'(NumBeats) - 1) begin
                    lo_d   = sdram.data_read;
                    beat_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Arbiter state; reset points the round-robin at client 3 so client 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            id_q      <= '0;
            ptr_q     <= client_t'(NumClients - 1);
            addr_q    <= '0;
            ba_addr_q <= '0;
            beat_q    <= 1'b0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            ba_addr_q <= ba_addr_d;
            beat_q    <= beat_d;
            lo_q      <= lo_d;
        end
    end

    jtvigil_romarb_slot #(.DataW(8)) u_slot0 (
        .clk(clk), .rst(rst), .cs(c0_cs), .addr(c0_addr), .fill(fill_en[0]),
        .fill_tag(addr_q), .fill_data(byte_fill), .hit(hit[0]), .ok(c0_ok), .data(c0_data)
    );
    jtvigil_romarb_slot #(.DataW(8)) u_slot1 (
        .clk(clk), .rst(rst), .cs(c1_cs), .addr(c1_addr), .fill(fill_en[1]),
        .fill_tag(addr_q), .fill_data(byte_fill), .hit(hit[1]), .ok(c1_ok), .data(c1_data)
    );
    jtvigil_romarb_slot #(.DataW(32)) u_slot2 (
        .clk(clk), .rst(rst), .cs(c2_cs), .addr(c2_addr), .fill(fill_en[2]),
        .fill_tag(addr_q), .fill_data(wide_fill2), .hit(hit[2]), .ok(c2_ok), .data(c2_data)
    );
    jtvigil_romarb_slot #(.DataW(32)) u_slot3 (
        .clk(clk), .rst(rst), .cs(c3_cs), .addr(c3_addr), .fill(fill_en[3]),
        .fill_tag(addr_q), .fill_data(wide_fill3), .hit(hit[3]), .ok(c3_ok), .data(c3_data)
    );

endmodule

// File: tb/tb_jtvigil_romarb.sv
// Directed bench for jtvigil_romarb with a per-cycle cache model checking ok/data.
module tb_jtvigil_romarb;

    localparam logic [21:0] Off0 = 22'h000000;
    localparam logic [21:0] Off1 = 22'h010000;
    localparam logic [21:0] Off2 = 22'h100000;
    localparam logic [21:0] Off3 = 22'h3FFFF0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cs_r = '0;
    logic [16:0] addr_r [4] = '{default: '0};
    logic [7:0]  c0_data, c1_data;
    logic [31:0] c2_data, c3_data;
    logic        c0_ok, c1_ok, c2_ok, c3_ok;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Cache model and pending-fill description driven by the SDRAM responder.
    bit          m_valid [4] = '{default: 1'b0};
    logic [16:0] m_tag   [4] = '{default: '0};
    logic [31:0] m_data  [4] = '{default: '0};
    bit          exp_ok  [4] = '{default: 1'b0};
    bit          f_en = 1'b0;
    int          f_c  = 0;
    int          f_nb = 1;
    logic [16:0] f_tag = '0;
    logic [15:0] f_b0 = '0, f_b1 = '0;
    logic [21:0] last_ba = '0;

    jtvigil_romarb_if bus ();

    jtvigil_romarb #(
        .C0_OFFSET(Off0), .C1_OFFSET(Off1), .C2_OFFSET(Off2), .C3_OFFSET(Off3)
    ) dut (
        .clk(clk), .rst(rst),
        .c0_cs(cs_r[0]), .c0_addr(addr_r[0]), .c0_data(c0_data), .c0_ok(c0_ok),
        .c1_cs(cs_r[1]), .c1_addr(addr_r[1]), .c1_data(c1_data), .c1_ok(c1_ok),
        .c2_cs(cs_r[2]), .c2_addr(addr_r[2]), .c2_data(c2_data), .c2_ok(c2_ok),
        .c3_cs(cs_r[3]), .c3_addr(addr_r[3]), .c3_data(c3_data), .c3_ok(c3_ok),
        .sdram(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] exp_ba(input int c, input logic [16:0] tag);
        logic [21:0] off;
        off = (c == 0) ? Off0 : (c == 1) ? Off1 : (c == 2) ? Off2 : Off3;
        if (c < 2) return off + 22'(tag / 2);
        return off + 22'(tag) * 22'd2;
    endfunction

    function automatic logic [31:0] fill_val(input int k);
        if (k < 2) return {24'd0, (f_tag[0] ? f_b0[15:8] : f_b0[7:0])};
        if (f_nb == 2) return {f_b1, f_b0};
        return {m_data[k][31:16], f_b0};
    endfunction

    function automatic logic [31:0] act_data(input int k);
        case (k)
            0: return {24'd0, c0_data};
            1: return {24'd0, c1_data};
            2: return c2_data;
            default: return c3_data;
        endcase
    endfunction

    // Model: ok is high the cycle after the client hits in its (post-fill) entry.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                m_valid[k] <= 1'b0;
                m_tag[k]   <= '0;
                m_data[k]  <= '0;
                exp_ok[k]  <= 1'b0;
            end else if (f_en && f_c == k) begin
                m_valid[k] <= 1'b1;
                m_tag[k]   <= f_tag;
                m_data[k]  <= fill_val(k);
                exp_ok[k]  <= cs_r[k] && (addr_r[k] == f_tag);
            end else begin
                exp_ok[k]  <= cs_r[k] && m_valid[k] && (addr_r[k] == m_tag[k]);
            end
        end
    end

    // Per-cycle comparison of every client's ok, and its data while ok is expected.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] oks;
            oks = {c3_ok, c2_ok, c1_ok, c0_ok};
            for (int k = 0; k < 4; k++) begin
                check($sformatf("ok%0d", k), 64'(oks[k]), 64'(exp_ok[k]));
                if (exp_ok[k]) check($sformatf("data%0d", k), 64'(act_data(k)), 64'(m_data[k]));
            end
        end
    end

    // SDRAM responder for one transfer expected from client c at address tag.
    task automatic serve(input int c, input logic [16:0] tag, input int nb,
                         input logic [15:0] b0, input logic [15:0] b1,
                         input bit chg, input logic [16:0] new_addr);
        int n;
        n = 0;
        while (bus.ba_rd !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        check($sformatf("rd_rise c%0d", c), 64'(bus.ba_rd), 64'd1);
        last_ba = bus.ba_addr;
        check($sformatf("ba_addr c%0d", c), 64'(bus.ba_addr), 64'(exp_ba(c, tag)));
        bus.ba_ack = 1'b1;
        step(1);
        bus.ba_ack = 1'b0;
        check("rd_drop", 64'(bus.ba_rd), 64'd0);
        if (chg) addr_r[c] = new_addr;
        bus.ba_dok    = 1'b1;
        bus.data_read = b0;
        if (nb == 2) begin
            step(1);
            bus.data_read = b1;
        end
        bus.ba_rdy = 1'b1;
        f_en = 1'b1; f_c = c; f_tag = tag; f_nb = nb; f_b0 = b0; f_b1 = b1;
        step(1);
        bus.ba_dok = 1'b0;
        bus.ba_rdy = 1'b0;
        f_en       = 1'b0;
    endtask

    task automatic no_rd(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            check(name, 64'(bus.ba_rd), 64'd0);
            step(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ba_ack = 1'b0; bus.ba_dok = 1'b0; bus.ba_rdy = 1'b0; bus.data_read = '0;
        step(1);
        chk_en = 1'b1;
        step(2);
        rst = 1'b0;
        check("reset ba_addr", 64'(bus.ba_addr), 64'd0);
        no_rd("reset ba_rd", 2);

        // Byte client miss, odd address selects the high byte.
        cs_r[0] = 1'b1; addr_r[0] = 17'h00011;
        serve(0, 17'h00011, 1, 16'hBEEF, 16'h0, 1'b0, '0);
        check("c0 ba_addr literal", 64'(last_ba), 64'h000008);
        check("c0_ok literal", 64'(c0_ok), 64'd1);
        check("c0_data literal", 64'(c0_data), 64'hBE);
        no_rd("c0 hit no rd", 3);

        // Graphics client two-beat fill.
        cs_r[2] = 1'b1; addr_r[2] = 17'h00004;
        serve(2, 17'h00004, 2, 16'h1234, 16'h5678, 1'b0, '0);
        check("c2 ba_addr literal", 64'(last_ba), 64'h100008);
        check("c2_data literal", 64'(c2_data), 64'h56781234);
        check("c2_ok literal", 64'(c2_ok), 64'd1);

        // Repeat access hits without touching SDRAM.
        cs_r[2] = 1'b0;
        step(1);
        cs_r[2] = 1'b1;
        step(1);
        check("c2 rehit ok", 64'(c2_ok), 64'd1);
        no_rd("c2 rehit no rd", 4);

        // Round-robin order from reset, with clients 0/1 re-pending after their fills.
        cs_r = '0; rst = 1'b1;
        step(2);
        rst = 1'b0;
        addr_r[0] = 17'h00020; addr_r[1] = 17'h00030;
        addr_r[2] = 17'h00008; addr_r[3] = 17'h0000A;
        cs_r = 4'hF;
        serve(0, 17'h00020, 1, 16'h1122, 16'h0, 1'b0, '0);
        addr_r[0] = 17'h00022;
        serve(1, 17'h00030, 1, 16'h3344, 16'h0, 1'b0, '0);
        addr_r[1] = 17'h00033;
        serve(2, 17'h00008, 2, 16'h5566, 16'h7788, 1'b0, '0);
        serve(3, 17'h0000A, 1, 16'h99AA, 16'h0, 1'b0, '0);
        check("c3 wrap ba_addr literal", 64'(last_ba), 64'h000004);
        check("c3 short fill literal", 64'(c3_data), 64'h000099AA);
        serve(0, 17'h00022, 1, 16'hBBCC, 16'h0, 1'b0, '0);
        serve(1, 17'h00033, 1, 16'hDDEE, 16'h0, 1'b0, '0);
        check("c1 odd byte literal", 64'(c1_data), 64'hDD);
        addr_r[2] = 17'h00009;
        serve(2, 17'h00009, 1, 16'hABCD, 16'h0, 1'b0, '0);
        check("c2 short fill keeps hi", 64'(c2_data), 64'h7788ABCD);

        // Reset one cycle after ack aborts the transfer; stray beats fill nothing.
        addr_r[3] = 17'h0000C;
        begin
            int n;
            n = 0;
            while (bus.ba_rd !== 1'b1 && n < 40) begin
                step(1);
                n++;
            end
        end
        check("c3 abort ba_addr literal", 64'(bus.ba_addr), 64'h000008);
        bus.ba_ack = 1'b1;
        step(1);
        bus.ba_ack = 1'b0;
        rst = 1'b1; cs_r = '0;
        bus.ba_dok = 1'b1; bus.data_read = 16'hAAAA;
        step(1);
        rst = 1'b0;
        check("abort ba_rd", 64'(bus.ba_rd), 64'd0);
        check("abort c3_ok", 64'(c3_ok), 64'd0);
        bus.ba_rdy = 1'b1; bus.data_read = 16'h5555;
        no_rd("stray beats", 2);
        bus.ba_dok = 1'b0; bus.ba_rdy = 1'b0;
        cs_r[3] = 1'b1;
        step(1);
        check("c3 still invalid", 64'(c3_ok), 64'd0);
        serve(3, 17'h0000C, 1, 16'h0F0F, 16'h0, 1'b0, '0);
        check("c3 refill literal", 64'(c3_data), 64'h00000F0F);

        // Address change during DATA: fill keeps the latched tag.
        cs_r[1] = 1'b1; addr_r[1] = 17'h00010;
        serve(1, 17'h00010, 1, 16'h4455, 16'h0, 1'b1, 17'h00020);
        check("c1 moved ok low", 64'(c1_ok), 64'd0);
        addr_r[1] = 17'h00010;
        step(1);
        check("c1 old tag hit", 64'(c1_ok), 64'd1);
        check("c1 old tag data", 64'(c1_data), 64'h55);
        check("c1 old tag no rd", 64'(bus.ba_rd), 64'd0);
        addr_r[1] = 17'h00020;
        serve(1, 17'h00020, 1, 16'h6677, 16'h0, 1'b0, '0);
        check("c1 new ba_addr literal", 64'(last_ba), 64'h010010);
        step(3);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
